// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result handshake plus the 1-bit full adder taps.
// Ovf exists only when OVERFLOW_DETECT_EN is defined.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             Start;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             CinInit;
    logic             Ready;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             CoutFinal;
    logic             FaA;
    logic             FaB;
    logic             FaCin;
    logic             FaS;
    logic             FaCout;
`ifdef OVERFLOW_DETECT_EN
    logic             Ovf;
`endif
    modport master (
        output Start, OpA, OpB, CinInit, FaS, FaCout,
        input  Ready, Done, Sum, CoutFinal, FaA, FaB, FaCin
`ifdef OVERFLOW_DETECT_EN
        , input Ovf
`endif
    );
    modport slave (
        input  Start, OpA, OpB, CinInit, FaS, FaCout,
        output Ready, Done, Sum, CoutFinal, FaA, FaB, FaCin
`ifdef OVERFLOW_DETECT_EN
        , output Ovf
`endif
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder sequencer around an external full adder.
// Define OVERFLOW_DETECT_EN to add the signed-overflow flag Ovf.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic               Clk,
    input logic               Rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] sha_q, shb_q, sum_q, sum_nxt;
    logic [WIDTH-2:0] shs_q;
    logic             carry_q, cout_q, last;
    logic [CW-1:0]    cnt_q;
`ifdef OVERFLOW_DETECT_EN
    logic             ovf_q;
`endif
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign sum_nxt = {bus.FaS, shs_q};
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE)  ? (bus.Start ? SHIFT : IDLE) :
                  (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end
    always_comb begin
        bus.Ready     = state_q == IDLE;
        bus.Done      = state_q == DONE;
        bus.FaA       = (state_q == SHIFT) & sha_q[0];
        bus.FaB       = (state_q == SHIFT) & shb_q[0];
        bus.FaCin     = (state_q == SHIFT) & carry_q;
        bus.Sum       = sum_q;
        bus.CoutFinal = cout_q;
`ifdef OVERFLOW_DETECT_EN
        bus.Ovf       = ovf_q;
`endif
    end
    // Partial sum keeps only the upper WIDTH-1 bits; the newest bit comes straight from FaS.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sha_q   <= '0;
            shb_q   <= '0;
            shs_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf_q   <= 1'b0;
`endif
        end else if (state_q == IDLE && bus.Start) begin
            sha_q   <= bus.OpA;
            shb_q   <= bus.OpB;
            carry_q <= bus.CinInit;
            cnt_q   <= '0;
        end else if (state_q == SHIFT) begin
            sha_q   <= sha_q >> 1;
            shb_q   <= shb_q >> 1;
            shs_q   <= sum_nxt[WIDTH-1:1];
            carry_q <= bus.FaCout;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                sum_q  <= sum_nxt;
                cout_q <= bus.FaCout;
`ifdef OVERFLOW_DETECT_EN
                ovf_q  <= carry_q ^ bus.FaCout;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vector table plus handshake/abort sequences, WIDTH=8.
// The bench models the full adder combinationally on the Fa* taps.
module tb_serial_adder_ctrl;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    serial_adder_ctrl_if #(.WIDTH(8)) bus ();
    serial_adder_ctrl #(.WIDTH(8)) dut (.Clk(Clk), .Rst(Rst), .bus(bus.slave));
    always #5 Clk = ~Clk;
    assign bus.FaS    = bus.FaA ^ bus.FaB ^ bus.FaCin;
    assign bus.FaCout = (bus.FaA & bus.FaB) | (bus.FaA & bus.FaCin) | (bus.FaB & bus.FaCin);
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;
    vec_t vecs[9];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask
    task automatic check_ovf(input string name, input logic exp);
`ifdef OVERFLOW_DETECT_EN
        check(name, 32'(bus.Ovf), 32'(exp));
`endif
    endtask
    // One add from IDLE; checks FA taps each shift cycle and that Sum holds its old value.
    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] prev, output int lat);
        int m;
        logic c;
        bus.OpA = a;
        bus.OpB = b;
        bus.CinInit = cin;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) begin
                m = (1 << i) - 1;
                c = 1'(((int'(a) & m) + (int'(b) & m) + int'(cin)) >> i);
                check($sformatf("fa_a[%0d]", i), 32'(bus.FaA), 32'(a[i]));
                check($sformatf("fa_b[%0d]", i), 32'(bus.FaB), 32'(b[i]));
                check($sformatf("fa_cin[%0d]", i), 32'(bus.FaCin), 32'(c));
                if (i == 7) check("sum_held", 32'(bus.Sum), 32'(prev));
            end
            tick();
            if (bus.Done) begin
                lat = i + 1;
                break;
            end
        end
    endtask
    initial begin
        int lat, e, d1, d2, dones;
        logic [7:0] prev;
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        bus.Start = 1'b0;
        bus.OpA = '0;
        bus.OpB = '0;
        bus.CinInit = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(bus.Ready), 32'd1);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_sum", 32'(bus.Sum), 32'd0);
        check("rst_cout", 32'(bus.CoutFinal), 32'd0);
        check("rst_fa", {29'd0, bus.FaA, bus.FaB, bus.FaCin}, 32'd0);
        check_ovf("rst_ovf", 1'b0);
        Rst = 1'b0;
        tick();
        prev = 8'h00;
        for (int v = 0; v < 9; v++) begin
            do_add(vecs[v].a, vecs[v].b, vecs[v].cin, prev, lat);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'd8);
            check($sformatf("v%0d_ready_in_done", v), 32'(bus.Ready), 32'd0);
            check($sformatf("v%0d_sum", v), 32'(bus.Sum), 32'(vecs[v].sum));
            check($sformatf("v%0d_cout", v), 32'(bus.CoutFinal), 32'(vecs[v].cout));
            check_ovf($sformatf("v%0d_ovf", v), vecs[v].ovf);
            tick();
            check($sformatf("v%0d_done_pulse", v), 32'(bus.Done), 32'd0);
            check($sformatf("v%0d_ready", v), 32'(bus.Ready), 32'd1);
            check($sformatf("v%0d_sum_hold", v), 32'(bus.Sum), 32'(vecs[v].sum));
            prev = vecs[v].sum;
        end
        // Back-to-back with Start held high
        bus.OpA = 8'hFF;
        bus.OpB = 8'h00;
        bus.CinInit = 1'b1;
        bus.Start = 1'b1;
        tick();
        bus.OpA = 8'hAA;
        bus.OpB = 8'h55;
        bus.CinInit = 1'b0;
        e = 0;
        d1 = -1;
        for (int i = 0; i < 20 && d1 < 0; i++) begin
            tick();
            e++;
            if (bus.Done) d1 = e;
        end
        check("b2b_first_latency", 32'(d1), 32'd8);
        check("b2b_first_sum", 32'(bus.Sum), 32'h00);
        check("b2b_first_cout", 32'(bus.CoutFinal), 32'd1);
        tick();
        e++;
        check("b2b_ready", 32'(bus.Ready), 32'd1);
        tick();
        e++;
        bus.Start = 1'b0;
        check("b2b_reaccept", 32'(bus.Ready), 32'd0);
        d2 = -1;
        for (int i = 0; i < 20 && d2 < 0; i++) begin
            tick();
            e++;
            if (bus.Done) d2 = e;
        end
        check("b2b_gap", 32'(d2 - d1), 32'd10);
        check("b2b_second_sum", 32'(bus.Sum), 32'hFF);
        check("b2b_second_cout", 32'(bus.CoutFinal), 32'd0);
        tick();
        // Start while busy is ignored
        bus.OpA = 8'h05;
        bus.OpB = 8'h03;
        bus.CinInit = 1'b0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                bus.Start = 1'b1;
                bus.OpA = 8'h11;
            end else begin
                bus.Start = 1'b0;
            end
            tick();
            if (bus.Done) dones++;
        end
        check("busy_start_dones", 32'(dones), 32'd1);
        check("busy_start_sum", 32'(bus.Sum), 32'h08);
        check("busy_start_ready", 32'(bus.Ready), 32'd1);
        // Reset mid-operation aborts without Done
        bus.OpA = 8'hAA;
        bus.OpB = 8'h55;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        tick();
        Rst = 1'b1;
        tick();
        check("abort_ready", 32'(bus.Ready), 32'd1);
        check("abort_done", 32'(bus.Done), 32'd0);
        check("abort_sum", 32'(bus.Sum), 32'd0);
        check("abort_cout", 32'(bus.CoutFinal), 32'd0);
        check_ovf("abort_ovf", 1'b0);
        Rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.Done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_idle", 32'(bus.Ready), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
